register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 8, width of each register and of the data ports.
REQ-002 Parameter ADDR_W, default 4, width of every select port; register count = 2**ADDR_W (16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 replaceData  input  DATA_W  write data.
REQ-006 replaceSel  input  ADDR_W  write address.
REQ-007 A_sel  input  ADDR_W  read address, port A.
REQ-008 B_sel  input  ADDR_W  read address, port B.
REQ-009 A  output  DATA_W  contents of register A_sel.
REQ-010 B  output  DATA_W  contents of register B_sel.

Function
REQ-011 The block SHALL hold 2**ADDR_W registers of DATA_W bits, indices 0..2**ADDR_W-1; register 0 is an ordinary writable register, not hard-wired.
REQ-012 No write enable: at every rising clk edge with reset low, register[replaceSel] SHALL load replaceData.
REQ-013 Only the addressed register SHALL change on a write; all others hold.
REQ-014 A SHALL equal register[A_sel] and B SHALL equal register[B_sel] combinationally; zero-cycle read latency after a select change.
REQ-015 Write-to-read latency: a value written at edge N SHALL appear on A/B immediately after edge N; no write-through bypass, so before edge N a read of replaceSel returns the old value.
REQ-016 A_sel and B_sel SHALL be independent; both may select the same register, giving A == B.
REQ-017 Both read ports may address the register being written in the same cycle; each returns the pre-edge value until the edge, then the new value.
REQ-018 Every select value is in range (full decode); no wrap or out-of-range case exists.
REQ-019 Any X/Z on replaceSel at a write edge is a bench error; the design is not required to guard it.

Reset
REQ-020 With reset high at a rising clk edge, all registers SHALL clear to 0; the write of that cycle SHALL be suppressed (reset has priority).
REQ-021 After reset, A and B SHALL read 0 for any select until written.
REQ-022 Reset asserted mid-operation SHALL clear all previously written contents on that edge; writing resumes on the first edge with reset low.

Structure
REQ-023 DATA_W, ADDR_W defaults and the derived register count SHALL live in a shared package (register_file_pkg) referenced by the module and the bench.
REQ-024 Storage SHALL be one array of registers in register_file; one sub-module, register_file_read_mux (DATA_W-wide 2**ADDR_W:1 mux), SHALL be instantiated twice, once for A and once for B.

Verification
REQ-025 Reset high one edge, then A_sel=0..15 sweep -> A=0 and B=0 at every select.
REQ-026 replaceData=8'hAA, replaceSel=0, one edge; A_sel=B_sel=0 -> A=8'hAA, B=8'hAA.
REQ-027 Then replaceData=8'hBB, replaceSel=1, one edge; A_sel=1, B_sel=0 -> A=8'hBB, B=8'hAA.
REQ-028 Then replaceData=8'hCC, replaceSel=2, one edge; A_sel=2, B_sel=1 -> A=8'hCC, B=8'hBB; register 0 still 8'hAA.
REQ-029 A_sel=3 with replaceSel=3, replaceData=8'h5A: before edge A=0, after edge A=8'h5A (no bypass).
REQ-030 Reset high with replaceSel=4, replaceData=8'hFF, one edge -> all registers 0, register 4 reads 0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared sizing for the register file and anything that talks to it.
//   DATA_W_DEF : default width of each register and of the data ports
//   ADDR_W_DEF : default width of every select port
//   NUM_REGS   : register count derived from the default select width
package register_file_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

endpackage

// File: rtl/register_file_read_mux.sv
// One read port of the register file: selects one of the 2**ADDR_W
// registers onto the output with no storage in the path.
//   regs : full register array, one DATA_W entry per index
//   sel  : index of the register to present
//   dout : contents of regs[sel]
module register_file_read_mux
  import register_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] sel,
  output logic [DATA_W-1:0] dout
);

  // The select spans exactly the array depth, so every value decodes to a
  // real register and no default/out-of-range handling is needed.
  assign dout = regs[sel];

endmodule

// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file with one write port and two independent
// combinational read ports.
//   clk         : single clock, all state changes on its rising edge
//   reset       : synchronous active-high reset, clears every register and
//                 takes priority over the write of that cycle
//   replaceData : write data, loaded every edge (there is no write enable)
//   replaceSel  : write address
//   A_sel       : read address for port A
//   B_sel       : read address for port B
//   A           : contents of register A_sel
//   B           : contents of register B_sel
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] replaceData,
  input  logic [ADDR_W-1:0] replaceSel,
  input  logic [ADDR_W-1:0] A_sel,
  input  logic [ADDR_W-1:0] B_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam int REG_N = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [REG_N];

  // Register 0 is ordinary storage. Reads are taken straight from the array,
  // so a write only becomes visible after its edge (no bypass path).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else begin
      regs[replaceSel] <= replaceData;
    end
  end

  register_file_read_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) uReadA (
    .regs (regs),
    .sel  (A_sel),
    .dout (A)
  );

  register_file_read_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) uReadB (
    .regs (regs),
    .sel  (B_sel),
    .dout (B)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed reset/write/read cases followed by
// randomized traffic checked against an array model of the register file.
module tb_register_file;
  import register_file_pkg::*;

  localparam int DATA_W = DATA_W_DEF;
  localparam int ADDR_W = ADDR_W_DEF;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] replaceData = '0;
  logic [ADDR_W-1:0] replaceSel = '0;
  logic [ADDR_W-1:0] A_sel = '0;
  logic [ADDR_W-1:0] B_sel = '0;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;

  logic [DATA_W-1:0] model [NUM_REGS];
  int vecCnt = 0;
  int errCnt = 0;

  register_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .replaceData (replaceData),
    .replaceSel  (replaceSel),
    .A_sel       (A_sel),
    .B_sel       (B_sel),
    .A           (A),
    .B           (B)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the same rule the spec states:
  // reset clears everything, otherwise the addressed register loads the data.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else begin
      model[replaceSel] = replaceData;
    end
    #1;
  endtask

  task automatic write(input logic [ADDR_W-1:0] sel, input logic [DATA_W-1:0] d);
    replaceSel  = sel;
    replaceData = d;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = 'x;

    // Reset, then sweep every select on both ports.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    replaceSel = 4'd5;
    replaceData = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      A_sel = ADDR_W'(i);
      B_sel = ADDR_W'(NUM_REGS - 1 - i);
      #1;
      checkVal($sformatf("rst_A[%0d]", i), A, 8'h00);
      checkVal($sformatf("rst_B[%0d]", NUM_REGS - 1 - i), B, 8'h00);
    end

    // Register 0 is writable.
    write(4'd0, 8'hAA);
    A_sel = 4'd0; B_sel = 4'd0; #1;
    checkVal("w0_A", A, 8'hAA);
    checkVal("w0_B", B, 8'hAA);

    write(4'd1, 8'hBB);
    A_sel = 4'd1; B_sel = 4'd0; #1;
    checkVal("w1_A", A, 8'hBB);
    checkVal("w1_B", B, 8'hAA);

    write(4'd2, 8'hCC);
    A_sel = 4'd2; B_sel = 4'd1; #1;
    checkVal("w2_A", A, 8'hCC);
    checkVal("w2_B", B, 8'hBB);
    B_sel = 4'd0; #1;
    checkVal("w2_reg0", B, 8'hAA);

    // No bypass: read of the register being written shows old value until edge.
    A_sel = 4'd3; B_sel = 4'd3;
    replaceSel = 4'd3; replaceData = 8'h5A; #1;
    checkVal("nobyp_A_pre", A, 8'h00);
    checkVal("nobyp_B_pre", B, 8'h00);
    tick();
    checkVal("nobyp_A_post", A, 8'h5A);
    checkVal("nobyp_B_post", B, 8'h5A);

    // Reset beats the concurrent write and clears earlier contents.
    reset = 1'b1;
    replaceSel = 4'd4; replaceData = 8'hFF;
    tick();
    reset = 1'b0;
    replaceSel = 4'd4; replaceData = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      A_sel = ADDR_W'(i);
      B_sel = ADDR_W'(i);
      #1;
      checkVal($sformatf("rst2_A[%0d]", i), A, 8'h00);
      checkVal($sformatf("rst2_B[%0d]", i), B, 8'h00);
    end

    // Randomized traffic with occasional reset; check both before and after
    // each edge so the no-bypass timing is exercised on random addresses.
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 24) == 0);
      replaceSel  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      replaceData = DATA_W'($urandom);
      A_sel       = ($urandom_range(0, 3) == 0) ? replaceSel
                                                : ADDR_W'($urandom_range(0, NUM_REGS - 1));
      B_sel       = ($urandom_range(0, 3) == 0) ? A_sel
                                                : ADDR_W'($urandom_range(0, NUM_REGS - 1));
      #1;
      checkVal("rnd_A_pre", A, model[A_sel]);
      checkVal("rnd_B_pre", B, model[B_sel]);
      tick();
      checkVal("rnd_A_post", A, model[A_sel]);
      checkVal("rnd_B_post", B, model[B_sel]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
